// File: rtl/exec_skid_stage_pkg.sv
// Shared types and constants for the decode->execute skid stage.
// Holds the default bundle geometry, the bubble opcode, the default-shape
// execute bundle struct and the occupancy state encoding.
package vec_pipe_pkg;

  localparam int OPC_W        = 5;
  localparam int WB_W         = 3;
  localparam int DEF_LANES    = 8;
  localparam int DEF_LANE_W   = 8;
  localparam int DEF_SCALAR_W = 32;
  localparam int DEF_IMM_W    = 8;
  localparam int DEF_VEC_W    = DEF_LANES * DEF_LANE_W;

  // Opcode presented whenever the stage outputs a bubble.
  localparam logic [OPC_W-1:0] NOP_OPCODE = 5'b11110;

  // Execute bundle in the default configuration; opcode is the MSB field.
  typedef struct packed {
    logic [OPC_W-1:0]        opcode;
    logic [DEF_SCALAR_W-1:0] reg1;
    logic [DEF_SCALAR_W-1:0] reg2;
    logic [DEF_IMM_W-1:0]    imm;
    logic [DEF_VEC_W-1:0]    vec1;
    logic [DEF_VEC_W-1:0]    vec2;
    logic [WB_W-1:0]         wb;
  } exec_bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/exec_skid_stage_if.sv
// Bus bundle between decode, the skid stage and execute.
// master : the environment side (drives flush, the upstream bundle and out_ready).
// slave  : the skid stage side (drives in_ready, the presented bundle and stall_count).
interface exec_skid_stage_if #(
  parameter int LANES       = vec_pipe_pkg::DEF_LANES,
  parameter int LANE_W      = vec_pipe_pkg::DEF_LANE_W,
  parameter int SCALAR_W    = vec_pipe_pkg::DEF_SCALAR_W,
  parameter int IMM_W       = vec_pipe_pkg::DEF_IMM_W,
  parameter int OPC_W       = vec_pipe_pkg::OPC_W,
  parameter int WB_W        = vec_pipe_pkg::WB_W,
  parameter int STALL_CNT_W = 16
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [OPC_W-1:0]          in_opcode;
  logic [SCALAR_W-1:0]       in_reg1_data;
  logic [SCALAR_W-1:0]       in_reg2_data;
  logic [IMM_W-1:0]          in_immediate;
  logic [LANES*LANE_W-1:0]   in_vec1_data;
  logic [LANES*LANE_W-1:0]   in_vec2_data;
  logic [WB_W-1:0]           in_wb_register;
  logic                      out_valid;
  logic                      out_ready;
  logic [OPC_W-1:0]          out_opcode;
  logic [SCALAR_W-1:0]       out_reg1_data;
  logic [SCALAR_W-1:0]       out_reg2_data;
  logic [IMM_W-1:0]          out_immediate;
  logic [LANES*LANE_W-1:0]   out_vec1_data;
  logic [LANES*LANE_W-1:0]   out_vec2_data;
  logic [WB_W-1:0]           out_wb_register;
  logic [STALL_CNT_W-1:0]    stall_count;

  modport master (
    output flush, in_valid, in_opcode, in_reg1_data, in_reg2_data, in_immediate,
           in_vec1_data, in_vec2_data, in_wb_register, out_ready,
    input  in_ready, out_valid, out_opcode, out_reg1_data, out_reg2_data,
           out_immediate, out_vec1_data, out_vec2_data, out_wb_register, stall_count
  );

  modport slave (
    input  flush, in_valid, in_opcode, in_reg1_data, in_reg2_data, in_immediate,
           in_vec1_data, in_vec2_data, in_wb_register, out_ready,
    output in_ready, out_valid, out_opcode, out_reg1_data, out_reg2_data,
           out_immediate, out_vec1_data, out_vec2_data, out_wb_register, stall_count
  );
endinterface

// File: rtl/exec_skid_stage_bundle_reg.sv
// exec_bundle_reg: one bundle-wide register with a valid bit.
// Ports: clk (state on falling edge), reset (sync, clears valid only),
//        clear (sync clear to BUBBLE, wins over load), load (capture d),
//        d/q (bundle), valid (entry occupied).
// Data bits carry no reset; consumers must qualify q with valid.
module exec_bundle_reg #(
  parameter int           W      = 8,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      data_d  = BUBBLE;
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = d;
      valid_d = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  always_ff @(negedge clk) begin
    data_q <= data_d;
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/exec_skid_stage.sv
// exec_skid_stage: decode->execute pipeline register with a 2-entry skid buffer.
// Ports: clk (all state on falling edge), reset (sync, active-high, overrides all),
//        bus (slave view): flush, in_valid/in_ready + in bundle,
//        out_valid/out_ready + out bundle, stall_count (saturating).
// in_ready is a flop, so out_ready never reaches decode combinationally.
module exec_skid_stage #(
  parameter int               LANES       = vec_pipe_pkg::DEF_LANES,
  parameter int               LANE_W      = vec_pipe_pkg::DEF_LANE_W,
  parameter int               SCALAR_W    = vec_pipe_pkg::DEF_SCALAR_W,
  parameter int               IMM_W       = vec_pipe_pkg::DEF_IMM_W,
  parameter int               OPC_W       = vec_pipe_pkg::OPC_W,
  parameter int               WB_W        = vec_pipe_pkg::WB_W,
  parameter logic [OPC_W-1:0] NOP_OPCODE  = vec_pipe_pkg::NOP_OPCODE,
  parameter int               STALL_CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  exec_skid_stage_if.slave  bus
);
  import vec_pipe_pkg::*;

  localparam int VEC_W = LANES * LANE_W;

  typedef struct packed {
    logic [OPC_W-1:0]    opcode;
    logic [SCALAR_W-1:0] reg1;
    logic [SCALAR_W-1:0] reg2;
    logic [IMM_W-1:0]    imm;
    logic [VEC_W-1:0]    vec1;
    logic [VEC_W-1:0]    vec2;
    logic [WB_W-1:0]     wb;
  } bundle_t;

  localparam int      BUNDLE_W = $bits(bundle_t);
  localparam bundle_t BUBBLE   = bundle_t'({NOP_OPCODE, {(BUNDLE_W-OPC_W){1'b0}}});

  skid_state_e            state_q, state_d;
  logic                   in_ready_q, in_ready_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  bundle_t in_b, main_d, main_q, skid_q, out_b;
  logic    main_vld, skid_vld;
  logic    main_load, main_clr, skid_load, skid_clr;
  logic    accept, consume;

  assign in_b = {bus.in_opcode, bus.in_reg1_data, bus.in_reg2_data, bus.in_immediate,
                 bus.in_vec1_data, bus.in_vec2_data, bus.in_wb_register};

  assign accept  = bus.in_valid & in_ready_q;
  assign consume = main_vld & bus.out_ready;

  // Anything parked in skid is older than the incoming bundle, so it refills main first.
  assign main_d = skid_vld ? skid_q : in_b;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (bus.flush) begin
      // Squash wins over a same-edge accept: the incoming bundle is dropped.
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (consume) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_load = 1'b1;
            skid_clr  = 1'b1;
            state_d   = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // Stall counter ignores flush; it only sees presented-but-not-taken cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_vld && !bus.out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  exec_bundle_reg #(.W(BUNDLE_W), .BUBBLE(BUBBLE)) u_main (
    .clk   (clk),
    .reset (reset),
    .clear (main_clr),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q),
    .valid (main_vld)
  );

  exec_bundle_reg #(.W(BUNDLE_W), .BUBBLE(BUBBLE)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (skid_clr),
    .load  (skid_load),
    .d     (in_b),
    .q     (skid_q),
    .valid (skid_vld)
  );

  // Output stage: bubble whenever main is empty, so unreset data never escapes.
  assign out_b = main_vld ? main_q : BUBBLE;

  assign bus.in_ready        = in_ready_q;
  assign bus.out_valid       = main_vld;
  assign bus.out_opcode      = out_b.opcode;
  assign bus.out_reg1_data   = out_b.reg1;
  assign bus.out_reg2_data   = out_b.reg2;
  assign bus.out_immediate   = out_b.imm;
  assign bus.out_vec1_data   = out_b.vec1;
  assign bus.out_vec2_data   = out_b.vec2;
  assign bus.out_wb_register = out_b.wb;
  assign bus.stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_exec_skid_stage.sv
module tb_exec_skid_stage;
  import vec_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  exec_skid_stage_if b ();
  exec_skid_stage_if #(.STALL_CNT_W(4)) b4 ();

  exec_skid_stage dut (.clk(clk), .reset(rst), .bus(b));
  exec_skid_stage #(.STALL_CNT_W(4)) dut4 (.clk(clk), .reset(rst4), .bus(b4));

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard: bundles the stage should currently hold, oldest first.
  exec_bundle_t mq[$];
  logic [15:0]  m_stall = '0;
  bit           m_ir    = 1'b1;

  typedef struct {
    bit         rst, fl, iv, ordy;
    logic [4:0] opc;
    bit         e_ov, e_ir;
    logic [4:0] e_opc;
    logic [15:0] e_st;
  } vec_t;
  vec_t tbl[21];

  function automatic exec_bundle_t bubble();
    exec_bundle_t r = '0;
    r.opcode = NOP_OPCODE;
    return r;
  endfunction

  function automatic exec_bundle_t mk(input logic [4:0] opc);
    exec_bundle_t r;
    r.opcode = opc;
    r.reg1   = 32'hA500_0000 | {27'd0, opc};
    r.reg2   = ~r.reg1;
    r.imm    = {3'd0, opc} + 8'h40;
    r.vec1   = {8{3'b101, opc}};
    r.vec2   = {2{r.reg2}};
    r.wb     = opc[2:0];
    return r;
  endfunction

  function automatic exec_bundle_t observed();
    exec_bundle_t r;
    r.opcode = b.out_opcode;
    r.reg1   = b.out_reg1_data;
    r.reg2   = b.out_reg2_data;
    r.imm    = b.out_immediate;
    r.vec1   = b.out_vec1_data;
    r.vec2   = b.out_vec2_data;
    r.wb     = b.out_wb_register;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input bit fl, input bit iv, input bit ordy, input exec_bundle_t d);
    b.flush          = fl;
    b.in_valid       = iv;
    b.out_ready      = ordy;
    b.in_opcode      = d.opcode;
    b.in_reg1_data   = d.reg1;
    b.in_reg2_data   = d.reg2;
    b.in_immediate   = d.imm;
    b.in_vec1_data   = d.vec1;
    b.in_vec2_data   = d.vec2;
    b.in_wb_register = d.wb;
  endtask

  // Advance one falling edge, update the scoreboard, then compare everything.
  task automatic tick();
    bit m_ov, acc, cons;
    exec_bundle_t incoming, exp_b;
    incoming = '{opcode: b.in_opcode, reg1: b.in_reg1_data, reg2: b.in_reg2_data,
                 imm: b.in_immediate, vec1: b.in_vec1_data, vec2: b.in_vec2_data,
                 wb: b.in_wb_register};
    m_ov = (mq.size() > 0);
    acc  = b.in_valid && m_ir;
    cons = m_ov && b.out_ready;
    if (rst) begin
      mq.delete();
      m_stall = '0;
      m_ir    = 1'b1;
    end else begin
      if (m_ov && !b.out_ready && m_stall != 16'hFFFF) m_stall++;
      if (b.flush) mq.delete();
      else begin
        if (cons) void'(mq.pop_front());
        if (acc)  mq.push_back(incoming);
      end
      m_ir = (mq.size() < 2);
    end
    @(negedge clk);
    #1;
    exp_b = bubble();
    if (mq.size() > 0) exp_b = mq[0];
    chk("sb_out_valid", 256'(b.out_valid), 256'(mq.size() > 0));
    chk("sb_in_ready", 256'(b.in_ready), 256'(m_ir));
    chk("sb_bundle", 256'(observed()), 256'(exp_b));
    chk("sb_stall", 256'(b.stall_count), 256'(m_stall));
  endtask

  task automatic tick4();
    @(negedge clk);
    #1;
  endtask

  initial begin
    exec_bundle_t s;
    // rst, fl, iv, ordy, opc,  e_ov, e_ir, e_opc, e_st
    tbl[0]  = '{0, 0, 1, 0, 5'h01, 1, 1, 5'h01, 16'd0};
    tbl[1]  = '{0, 0, 1, 0, 5'h02, 1, 0, 5'h01, 16'd1};
    tbl[2]  = '{0, 0, 1, 0, 5'h03, 1, 0, 5'h01, 16'd2};
    tbl[3]  = '{0, 0, 0, 0, 5'h00, 1, 0, 5'h01, 16'd3};
    tbl[4]  = '{0, 0, 0, 1, 5'h00, 1, 1, 5'h02, 16'd3};
    tbl[5]  = '{0, 0, 1, 1, 5'h03, 1, 1, 5'h03, 16'd3};
    tbl[6]  = '{0, 0, 0, 1, 5'h00, 0, 1, 5'h1E, 16'd3};
    tbl[7]  = '{0, 0, 1, 1, 5'h04, 1, 1, 5'h04, 16'd3};
    tbl[8]  = '{0, 0, 1, 1, 5'h05, 1, 1, 5'h05, 16'd3};
    tbl[9]  = '{0, 0, 0, 1, 5'h00, 0, 1, 5'h1E, 16'd3};
    tbl[10] = '{0, 0, 1, 0, 5'h06, 1, 1, 5'h06, 16'd3};
    tbl[11] = '{0, 0, 1, 0, 5'h07, 1, 0, 5'h06, 16'd4};
    tbl[12] = '{0, 0, 0, 0, 5'h00, 1, 0, 5'h06, 16'd5};
    tbl[13] = '{1, 1, 1, 0, 5'h09, 0, 1, 5'h1E, 16'd0};
    tbl[14] = '{0, 0, 1, 0, 5'h0A, 1, 1, 5'h0A, 16'd0};
    tbl[15] = '{0, 0, 1, 0, 5'h0B, 1, 0, 5'h0A, 16'd1};
    tbl[16] = '{0, 1, 1, 0, 5'h0D, 0, 1, 5'h1E, 16'd2};
    tbl[17] = '{0, 0, 0, 1, 5'h00, 0, 1, 5'h1E, 16'd2};
    tbl[18] = '{0, 0, 1, 1, 5'h0C, 1, 1, 5'h0C, 16'd2};
    tbl[19] = '{0, 0, 0, 0, 5'h00, 1, 1, 5'h0C, 16'd3};
    tbl[20] = '{0, 0, 0, 1, 5'h00, 0, 1, 5'h1E, 16'd3};

    apply(1'b0, 1'b0, 1'b0, '0);
    b4.flush = 1'b0; b4.in_valid = 1'b0; b4.out_ready = 1'b0;
    b4.in_opcode = '0; b4.in_reg1_data = '0; b4.in_reg2_data = '0;
    b4.in_immediate = '0; b4.in_vec1_data = '0; b4.in_vec2_data = '0;
    b4.in_wb_register = '0;

    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_out_valid", 256'(b.out_valid), 256'(1'b0));
    chk("reset_opcode", 256'(b.out_opcode), 256'(5'b11110));
    chk("reset_in_ready", 256'(b.in_ready), 256'(1'b1));
    chk("reset_stall", 256'(b.stall_count), 256'(16'd0));
    chk("reset_data", 256'({b.out_reg1_data, b.out_reg2_data, b.out_immediate,
                            b.out_vec1_data, b.out_vec2_data, b.out_wb_register}), 256'(0));

    // Single bundle, consumed immediately
    s = '0;
    s.opcode = 5'h03;
    s.reg1   = 32'h0000_0010;
    s.vec1   = 64'h0102_0304_0506_0708;
    apply(1'b0, 1'b1, 1'b1, s);
    tick();
    chk("single_valid", 256'(b.out_valid), 256'(1'b1));
    chk("single_bundle", 256'(observed()), 256'(s));
    apply(1'b0, 1'b0, 1'b1, '0);
    tick();
    chk("single_gone", 256'(b.out_valid), 256'(1'b0));
    chk("single_bubble", 256'(observed()), 256'(bubble()));
    tick();
    chk("single_once", 256'(b.out_valid), 256'(1'b0));

    // Table: back-pressure A/B/C, throughput, reset in FULL, flush in FULL
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst;
      apply(tbl[i].fl, tbl[i].iv, tbl[i].ordy, mk(tbl[i].opc));
      tick();
      chk($sformatf("row%0d_out_valid", i), 256'(b.out_valid), 256'(tbl[i].e_ov));
      chk($sformatf("row%0d_in_ready", i), 256'(b.in_ready), 256'(tbl[i].e_ir));
      chk($sformatf("row%0d_opcode", i), 256'(b.out_opcode), 256'(tbl[i].e_opc));
      chk($sformatf("row%0d_stall", i), 256'(b.stall_count), 256'(tbl[i].e_st));
    end
    rst = 1'b0;
    apply(1'b0, 1'b0, 1'b1, '0);

    // Narrow stall counter saturates at 4'hF
    tick();
    rst4 = 1'b0;
    b4.in_valid  = 1'b1;
    b4.in_opcode = 5'h07;
    b4.out_ready = 1'b0;
    tick4();
    chk("sat_accept", 256'(b4.out_valid), 256'(1'b1));
    chk("sat_start", 256'(b4.stall_count), 256'(4'd0));
    b4.in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick4();
      chk($sformatf("sat_stall_%0d", i), 256'(b4.stall_count), 256'((i > 15) ? 15 : i));
    end
    chk("sat_held_opcode", 256'(b4.out_opcode), 256'(5'h07));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
